// File: rtl/vco_sar_cal.sv
// Successive-approximation calibration of the VCO control-DAC code.
// Each step settles, counts divided-VCO ticks over a fixed window, then keeps or drops one bit.
module vco_sar_cal #(
    parameter int unsigned N_DAC      = 6,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned WIN_CYC    = 256,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned TOL        = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             vco_tick,
    output logic [N_DAC-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             ovf,
    output logic [CNT_W-1:0] meas_cnt
);

    localparam int unsigned MaxCyc = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int unsigned TmrW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam int unsigned KW     = (N_DAC > 1) ? $clog2(N_DAC) : 1;
    localparam logic [N_DAC-1:0] MidCode = N_DAC'(1) << (N_DAC - 1);

    typedef enum logic [2:0] {
        StIdle, StSettle, StMeasure, StDecide,
        StFinalSettle, StFinalMeasure, StFinalDecide, StDone
    } state_e;

    state_e           state_q, state_d;
    logic [N_DAC-1:0] code_q, code_d;
    logic [KW-1:0]    k_q, k_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [TmrW-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             locked_q, locked_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] diff;

    assign diff = (cnt_q >= tgt_q) ? (cnt_q - tgt_q) : (tgt_q - cnt_q);

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        k_d      = k_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        sat_d    = sat_q;
        tmr_d    = tmr_q;
        meas_d   = meas_q;
        busy_d   = busy_q;
        done_d   = done_q;
        locked_d = locked_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    tgt_d    = target;
                    k_d      = KW'(N_DAC - 1);
                    code_d   = MidCode;
                    done_d   = 1'b0;
                    locked_d = 1'b0;
                    ovf_d    = 1'b0;
                    busy_d   = 1'b1;
                    tmr_d    = '0;
                    state_d  = StSettle;
                end
            end
            StSettle, StFinalSettle: begin
                // Counter is held clear for the whole settle period.
                cnt_d = '0;
                sat_d = 1'b0;
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TmrW'(SETTLE_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = (state_q == StSettle) ? StMeasure : StFinalMeasure;
                end
            end
            StMeasure, StFinalMeasure: begin
                if (vco_tick) begin
                    if (cnt_q == '1) sat_d = 1'b1;
                    else             cnt_d = cnt_q + 1'b1;
                end
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == TmrW'(WIN_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = (state_q == StMeasure) ? StDecide : StFinalDecide;
                end
            end
            StDecide: begin
                meas_d = cnt_q;
                if (cnt_q > tgt_q) code_d[k_q] = 1'b0;
                if (k_q != '0) begin
                    k_d              = k_q - 1'b1;
                    code_d[k_q-1'b1] = 1'b1;
                    state_d          = StSettle;
                end else begin
                    state_d = StFinalSettle;
                end
            end
            StFinalDecide: begin
                meas_d   = cnt_q;
                locked_d = (diff <= CNT_W'(TOL));
                ovf_d    = sat_q;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= StIdle;
            code_q   <= MidCode;
            k_q      <= '0;
            tgt_q    <= '0;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            tmr_q    <= '0;
            meas_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            k_q      <= k_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            sat_q    <= sat_d;
            tmr_q    <= tmr_d;
            meas_q   <= meas_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            locked_q <= locked_d;
            ovf_q    <= ovf_d;
        end
    end

    assign dac_code = code_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign locked   = locked_q;
    assign ovf      = ovf_q;
    assign meas_cnt = meas_q;

endmodule

// File: tb/tb_vco_sar_cal.sv
// Directed bench for vco_sar_cal: VCO model yields 4*dac_code ticks per 256-cycle window.
// A second instance with CNT_W=8 and a stuck-high tick exercises saturation.
module tb_vco_sar_cal;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start, start2;
    logic [11:0] target;
    logic [7:0]  target2;
    logic        vco_tick, vco_tick2;
    logic [5:0]  dac_code, dac2;
    logic        busy, done, locked, ovf;
    logic        busy2, done2, locked2, ovf2;
    logic [11:0] meas_cnt;
    logic [7:0]  meas2;
    logic [5:0]  ph = '0;

    int n_pass = 0;
    int n_chk  = 0;
    int lat;
    int codes[$];

    always #5 clk = ~clk;

    // Period-64 pattern with dac_code ones: any 256-cycle window holds 4*dac_code ticks.
    always @(posedge clk) ph <= ph + 6'd1;
    assign vco_tick = (ph < dac_code);

    vco_sar_cal dut (
        .clk(clk), .rstn(rstn), .start(start), .target(target), .vco_tick(vco_tick),
        .dac_code(dac_code), .busy(busy), .done(done), .locked(locked), .ovf(ovf),
        .meas_cnt(meas_cnt)
    );

    vco_sar_cal #(.CNT_W(8)) dut2 (
        .clk(clk), .rstn(rstn), .start(start2), .target(target2), .vco_tick(vco_tick2),
        .dac_code(dac2), .busy(busy2), .done(done2), .locked(locked2), .ovf(ovf2),
        .meas_cnt(meas2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_seq(input string tag, input int n, input int exp [7]);
        check({tag, "_len"}, codes.size(), n);
        for (int i = 0; i < n && i < codes.size(); i++)
            check($sformatf("%s_%0d", tag, i), codes[i], exp[i]);
    endtask

    // Cycle 0 carries start; returns the cycle in which done is first seen high.
    task automatic run_cal(input logic [11:0] tgt, output int l);
        codes.delete();
        l = -1;
        @(negedge clk);
        start  = 1'b1;
        target = tgt;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            start  = 1'b0;
            target = 12'd0;
            if (n == 1) begin
                check("ack_busy", busy, 1);
                check("ack_done", done, 0);
            end
            if (busy && (codes.size() == 0 || dac_code != codes[$])) codes.push_back(dac_code);
            if (done) begin
                l = n;
                break;
            end
        end
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        start2    = 1'b0;
        target    = '0;
        target2   = '0;
        vco_tick2 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_code", dac_code, 32);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_locked", locked, 0);
        check("rst_ovf", ovf, 0);
        check("rst_meas", meas_cnt, 0);
        check("rst2_code", dac2, 32);
        rstn = 1'b1;
        @(negedge clk);

        run_cal(12'd100, lat);
        check_seq("seq100", 6, '{32, 16, 24, 28, 26, 25, 0});
        check("lat100", lat, 1912);
        check("busy100", busy, 0);
        check("code100", dac_code, 25);
        check("meas100", meas_cnt, 100);
        check("locked100", locked, 1);
        check("ovf100", ovf, 0);
        repeat (5) @(negedge clk);
        check("hold_done", done, 1);
        check("hold_code", dac_code, 25);

        run_cal(12'd40, lat);
        check("lat40", lat, 1912);
        check("code40", dac_code, 10);
        check("meas40", meas_cnt, 40);
        check("locked40", locked, 1);

        run_cal(12'd0, lat);
        check_seq("seq0", 7, '{32, 16, 8, 4, 2, 1, 0});
        check("code0", dac_code, 0);
        check("meas0", meas_cnt, 0);
        check("locked0", locked, 1);

        run_cal(12'd300, lat);
        check("code300", dac_code, 63);
        check("meas300", meas_cnt, 252);
        check("locked300", locked, 0);
        check("ovf300", ovf, 0);

        // Abort during the bit-3 window, then recalibrate from scratch.
        @(negedge clk);
        start  = 1'b1;
        target = 12'd100;
        for (int n = 1; n <= 600; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 599) check("pre_abort_code", dac_code, 24);
            if (n == 600) rstn = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b1;
        check("abort_code", dac_code, 32);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_meas", meas_cnt, 0);
        run_cal(12'd100, lat);
        check("lat_rerun", lat, 1912);
        check("code_rerun", dac_code, 25);
        check("locked_rerun", locked, 1);

        // Saturating instance; a start while busy must be ignored.
        codes.delete();
        lat = -1;
        @(negedge clk);
        start2  = 1'b1;
        target2 = 8'd200;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            start2 = (n == 700);
            if (n == 700) target2 = 8'd5;
            if (busy2 && (codes.size() == 0 || dac2 != codes[$])) codes.push_back(dac2);
            if (done2) begin
                lat = n;
                break;
            end
        end
        start2 = 1'b0;
        check_seq("seq_sat", 7, '{32, 16, 8, 4, 2, 1, 0});
        check("lat_sat", lat, 1912);
        check("meas_sat", meas2, 255);
        check("ovf_sat", ovf2, 1);
        check("locked_sat", locked2, 0);
        check("code_sat", dac2, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
